// File: rtl/board_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_io_pkg
//  Description : Shared constants for board_io_ctrl: data width and the
//                register offsets of the MMIO window.
//  Revision    : 1.0 - initial release
// ============================================================================
package board_io_pkg;

    localparam int C_DATA_W = 32;

    typedef logic [C_DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        REG_BTN_LEVEL   = 2'd0,
        REG_BTN_PRESSED = 2'd1,
        REG_LED         = 2'd2,
        REG_CYCLES      = 2'd3
    } reg_off_e;

endpackage : board_io_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : One button channel: 2-flop synchroniser, stability counter,
//                debounced level and a single-cycle rise indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             w_differ;
    logic             w_expire;

    assign w_differ = r_sync[1] ^ r_stable;
    assign w_expire = w_differ && (r_cnt == C_CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            // Any sample agreeing with the current level restarts the count.
            if (!w_differ || w_expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_expire) begin
                r_stable <= r_sync[1];
            end
        end
    end

    assign o_level = r_stable;
    assign o_rise  = w_expire & r_sync[1];

endmodule : btn_debounce
`default_nettype wire

// File: rtl/board_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : board_io_ctrl
//  Description : Reset synchroniser, processor clock enable, debounced buttons
//                and a small MMIO register window (BTN_LEVEL, BTN_PRESSED,
//                LED, CYCLES). CYCLES exists only with BOARD_IO_CYCLE_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int DIV_LOG2        = 1,
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LED_W           = 16
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
    input  logic [N_BTN-1:0]    btn_raw,
    output logic                sys_rst_n,
    output logic                cpu_ce,
    input  logic                mmio_sel,
    input  logic                mmio_we,
    input  logic [1:0]          mmio_addr,
    input  logic [C_DATA_W-1:0] mmio_wdata,
    output logic [C_DATA_W-1:0] mmio_rdata,
    output logic [LED_W-1:0]    LED
);

    logic [1:0]       r_rst_sync;
    logic             w_ce;
    logic [N_BTN-1:0] w_stable;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] r_pressed;
    logic [N_BTN-1:0] w_clr;
    logic [LED_W-1:0] r_led;
    word_t            r_rdata;
    word_t            w_rd_mux;
    word_t            w_cycles;
    logic             w_accept;
    logic             w_wr;
    logic             w_rd;
    logic             w_unused;

    // Reset asserts asynchronously, releases on the 2nd edge after CPU_RESETN.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign sys_rst_n = r_rst_sync[1];

    generate
        if (DIV_LOG2 == 0) begin : g_ce_always
            assign w_ce = sys_rst_n;
        end else begin : g_ce_div
            logic [DIV_LOG2-1:0] r_div;

            always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
                if (!CPU_RESETN) begin
                    r_div <= '0;
                end else if (!sys_rst_n) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            assign w_ce = sys_rst_n && (r_div == '1);
        end
    endgenerate

    assign cpu_ce = w_ce;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_btn_debounce (
                .clk     (CLK100MHZ),
                .rst_n   (CPU_RESETN),
                .i_btn   (btn_raw[gi]),
                .o_level (w_stable[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    assign w_accept = mmio_sel & w_ce;
    assign w_wr     = w_accept & mmio_we;
    assign w_rd     = w_accept & ~mmio_we;
    assign w_clr    = (w_wr && (mmio_addr == REG_BTN_PRESSED)) ?
                      mmio_wdata[N_BTN-1:0] : '0;

    // Upper write-data bits are only partially consumed depending on widths.
    assign w_unused = ^mmio_wdata;

    // A rise in the same cycle as a clear keeps its bit set.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_pressed <= '0;
        end else begin
            r_pressed <= (r_pressed & ~w_clr) | w_rise;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_led <= '0;
        end else if (w_wr && (mmio_addr == REG_LED)) begin
            r_led <= mmio_wdata[LED_W-1:0];
        end
    end

`ifdef BOARD_IO_CYCLE_CNT_EN
    word_t r_cycles;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_cycles <= '0;
        end else if (!sys_rst_n) begin
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = '0;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (mmio_addr)
            REG_BTN_LEVEL:   w_rd_mux[N_BTN-1:0] = w_stable;
            REG_BTN_PRESSED: w_rd_mux[N_BTN-1:0] = r_pressed;
            REG_LED:         w_rd_mux[LED_W-1:0] = r_led;
            default:         w_rd_mux            = w_cycles;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rd_mux;
        end
    end

    assign mmio_rdata = r_rdata;
    assign LED        = r_led;

endmodule : board_io_ctrl
`default_nettype wire

// File: tb/tb_board_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_io_ctrl
//  Description : Randomised self-checking bench for board_io_ctrl against a
//                sample-window reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_io_ctrl;
    import board_io_pkg::*;

    localparam int DIV_LOG2 = 2;
    localparam int N_BTN    = 4;
    localparam int DEB      = 8;
    localparam int LED_W    = 16;
    localparam int P        = 1 << DIV_LOG2;

    logic             CLK100MHZ;
    logic             CPU_RESETN;
    logic [N_BTN-1:0] btn_raw;
    logic             sys_rst_n;
    logic             cpu_ce;
    logic             mmio_sel;
    logic             mmio_we;
    logic [1:0]       mmio_addr;
    logic [31:0]      mmio_wdata;
    logic [31:0]      mmio_rdata;
    logic [LED_W-1:0] LED;

    board_io_ctrl #(
        .DIV_LOG2        (DIV_LOG2),
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (DEB),
        .LED_W           (LED_W)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .btn_raw    (btn_raw),
        .sys_rst_n  (sys_rst_n),
        .cpu_ce     (cpu_ce),
        .mmio_sel   (mmio_sel),
        .mmio_we    (mmio_we),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_rdata (mmio_rdata),
        .LED        (LED)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pin-sample history and architectural register values.
    int               m_edges;
    logic [N_BTN-1:0] m_hist [$];
    logic [N_BTN-1:0] m_stable;
    logic [N_BTN-1:0] m_pressed;
    logic [LED_W-1:0] m_led;
    logic [31:0]      m_rd;

    function automatic void model_reset();
        m_edges = 0;
        m_hist.delete();
        for (int i = 0; i < DEB + 2; i++) m_hist.push_back('0);
        m_stable  = '0;
        m_pressed = '0;
        m_led     = '0;
        m_rd      = '0;
    endfunction

    // cpu_ce is high in the cycle that ends every P-th edge after sys_rst_n rose.
    function automatic bit ce_now();
        return (m_edges >= 2) && (((m_edges - 1) % P) == 0);
    endfunction

    // A channel's level follows its synchronised pin once DEB consecutive
    // samples agree; hist[off] is the newest sample the comparator sees.
    function automatic logic [N_BTN-1:0] settled(input int off);
        logic [N_BTN-1:0] s;
        s = m_stable;
        for (int ch = 0; ch < N_BTN; ch++) begin
            bit same;
            same = 1'b1;
            for (int j = off; j < off + DEB; j++)
                if (m_hist[j][ch] != m_hist[off][ch]) same = 1'b0;
            if (same) s[ch] = m_hist[off][ch];
        end
        return s;
    endfunction

    function automatic void model_edge();
        bit               acc;
        logic [31:0]      rdv;
        logic [N_BTN-1:0] clr;
        logic [N_BTN-1:0] ns;
        acc = mmio_sel && ce_now();
        rdv = '0;
        case (mmio_addr)
            2'd0:    rdv[N_BTN-1:0] = m_stable;
            2'd1:    rdv[N_BTN-1:0] = m_pressed;
            2'd2:    rdv[LED_W-1:0] = m_led;
            default: rdv = '0;
        endcase
        if (acc && !mmio_we) m_rd = rdv;
        clr = (acc && mmio_we && mmio_addr == 2'd1) ? mmio_wdata[N_BTN-1:0] : '0;
        if (acc && mmio_we && mmio_addr == 2'd2) m_led = mmio_wdata[LED_W-1:0];
        m_hist.push_front(btn_raw);
        void'(m_hist.pop_back());
        ns        = settled(2);
        m_pressed = (m_pressed & ~clr) | (ns & ~m_stable);
        m_stable  = ns;
        m_edges++;
    endfunction

    task automatic tick();
        @(posedge CLK100MHZ);
        if (CPU_RESETN) model_edge();
        @(negedge CLK100MHZ);
    endtask

    task automatic mmio(input logic we, input logic [1:0] addr, input logic [31:0] wd);
        for (int i = 0; i < P && !ce_now(); i++) tick();
        mmio_sel   = 1'b1;
        mmio_we    = we;
        mmio_addr  = addr;
        mmio_wdata = wd;
        tick();
        mmio_sel = 1'b0;
        mmio_we  = 1'b0;
    endtask

    task automatic test_reset();
        CPU_RESETN = 1'b1;
        btn_raw = '0; mmio_sel = 0; mmio_we = 0; mmio_addr = 0; mmio_wdata = 0;
        #1 CPU_RESETN = 1'b0;
        model_reset();
        repeat (3) tick();
        n_tests++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys_rst_n got %b want 0", sys_rst_n); end
        n_tests++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ce got %b want 0", cpu_ce); end
        n_tests++; if (LED !== '0) begin n_fail++; $display("FAIL reset_led got %h want 0", LED); end
        n_tests++; if (mmio_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", mmio_rdata); end
        CPU_RESETN = 1'b1;
        tick();
        n_tests++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL sync_edge1 got %b want 0", sys_rst_n); end
        tick();
        n_tests++; if (sys_rst_n !== 1'b1) begin n_fail++; $display("FAIL sync_edge2 got %b want 1", sys_rst_n); end
    endtask

    task automatic test_clock_enable();
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (cpu_ce !== ce_now()) begin
                n_fail++; $display("FAIL cpu_ce cycle %0d got %b want %b", i, cpu_ce, ce_now());
            end
            tick();
        end
    endtask

    task automatic test_debounce_glitch();
        btn_raw = 4'b0010;
        repeat (5) tick();
        btn_raw = 4'b0000;
        repeat (12) tick();
        mmio(1'b0, REG_BTN_LEVEL, 32'h0);
        n_tests++; if (mmio_rdata !== 32'h0) begin n_fail++; $display("FAIL glitch_level got %h want 0", mmio_rdata); end
        mmio(1'b0, REG_BTN_PRESSED, 32'h0);
        n_tests++; if (mmio_rdata !== 32'h0) begin n_fail++; $display("FAIL glitch_pressed got %h want 0", mmio_rdata); end
    endtask

    task automatic test_debounce_press();
        btn_raw = 4'b0010;
        repeat (20) tick();
        mmio(1'b0, REG_BTN_LEVEL, 32'h0);
        n_tests++; if (mmio_rdata !== 32'h2) begin n_fail++; $display("FAIL press_level got %h want 2", mmio_rdata); end
        mmio(1'b0, REG_BTN_PRESSED, 32'h0);
        n_tests++; if (mmio_rdata !== 32'h2) begin n_fail++; $display("FAIL press_pressed got %h want 2", mmio_rdata); end
    endtask

    task automatic test_pressed_clear();
        btn_raw = 4'b0011;
        repeat (20) tick();
        mmio(1'b0, REG_BTN_PRESSED, 32'h0);
        n_tests++; if (mmio_rdata !== 32'h3) begin n_fail++; $display("FAIL clr_before got %h want 3", mmio_rdata); end
        mmio(1'b1, REG_BTN_PRESSED, 32'h1);
        mmio(1'b0, REG_BTN_PRESSED, 32'h0);
        n_tests++; if (mmio_rdata !== 32'h2) begin n_fail++; $display("FAIL clr_bit0 got %h want 2", mmio_rdata); end
        btn_raw = 4'b0001;
        repeat (20) tick();
        // Re-press channel 1 so its level rises exactly on an accepting edge.
        for (int i = 0; i < P && !ce_now(); i++) tick();
        repeat (3) tick();
        btn_raw = 4'b0011;
        repeat (9) tick();
        mmio(1'b1, REG_BTN_PRESSED, 32'h2);
        mmio(1'b0, REG_BTN_PRESSED, 32'h0);
        n_tests++; if (mmio_rdata !== 32'h2) begin n_fail++; $display("FAIL set_wins got %h want 2", mmio_rdata); end
        mmio(1'b1, REG_BTN_PRESSED, 32'h2);
        mmio(1'b0, REG_BTN_PRESSED, 32'h0);
        n_tests++; if (mmio_rdata !== 32'h0) begin n_fail++; $display("FAIL clr_bit1 got %h want 0", mmio_rdata); end
        mmio(1'b0, REG_BTN_LEVEL, 32'h0);
        n_tests++; if (mmio_rdata !== 32'h3) begin n_fail++; $display("FAIL level_both got %h want 3", mmio_rdata); end
    endtask

    task automatic test_led();
        mmio(1'b1, REG_LED, 32'hFFFF_A5A5);
        n_tests++; if (LED !== 16'hA5A5) begin n_fail++; $display("FAIL led_write got %h want a5a5", LED); end
        mmio(1'b0, REG_LED, 32'h0);
        n_tests++; if (mmio_rdata !== 32'h0000_A5A5) begin n_fail++; $display("FAIL led_read got %h want 0000a5a5", mmio_rdata); end
        for (int i = 0; i < P && ce_now(); i++) tick();
        mmio_sel = 1'b1; mmio_we = 1'b1; mmio_addr = REG_LED; mmio_wdata = 32'h1234;
        tick();
        mmio_sel = 1'b0; mmio_we = 1'b0;
        n_tests++; if (LED !== 16'hA5A5) begin n_fail++; $display("FAIL led_no_ce got %h want a5a5", LED); end
        n_tests++; if (mmio_rdata !== 32'h0000_A5A5) begin n_fail++; $display("FAIL rdata_hold got %h want 0000a5a5", mmio_rdata); end
        mmio(1'b1, REG_BTN_LEVEL, 32'hFFFF_FFFF);
        mmio(1'b0, REG_BTN_LEVEL, 32'h0);
        n_tests++; if (mmio_rdata !== 32'(m_stable)) begin n_fail++; $display("FAIL level_ro got %h want %h", mmio_rdata, 32'(m_stable)); end
    endtask

    task automatic test_cycles();
        logic [31:0] c1, c2;
        mmio(1'b0, REG_CYCLES, 32'h0);
        c1 = mmio_rdata;
        repeat (39) tick();
        mmio(1'b0, REG_CYCLES, 32'h0);
        c2 = mmio_rdata;
`ifdef BOARD_IO_CYCLE_CNT_EN
        n_tests++; if (c2 - c1 !== 32'd40) begin n_fail++; $display("FAIL cycles_delta got %0d want 40", c2 - c1); end
`else
        n_tests++; if (c1 !== 32'h0) begin n_fail++; $display("FAIL cycles_off1 got %h want 0", c1); end
        n_tests++; if (c2 !== 32'h0) begin n_fail++; $display("FAIL cycles_off2 got %h want 0", c2); end
`endif
    endtask

    task automatic test_random();
        logic        we;
        logic [1:0]  addr;
        mmio(1'b0, REG_BTN_LEVEL, 32'h0);
        n_tests++; if (mmio_rdata !== m_rd) begin n_fail++; $display("FAIL rnd_first got %h want %h", mmio_rdata, m_rd); end
        for (int it = 0; it < 40; it++) begin
            btn_raw = N_BTN'($urandom);
            repeat ($urandom_range(1, 14)) tick();
            addr = 2'($urandom_range(0, 2));
            we   = 1'($urandom_range(0, 1));
            mmio(we, addr, $urandom);
            n_tests++; if (mmio_rdata !== m_rd) begin n_fail++; $display("FAIL rnd_rdata it %0d got %h want %h", it, mmio_rdata, m_rd); end
            n_tests++; if (LED !== m_led) begin n_fail++; $display("FAIL rnd_led it %0d got %h want %h", it, LED, m_led); end
        end
        btn_raw = '0;
        repeat (20) tick();
        mmio(1'b0, REG_BTN_LEVEL, 32'h0);
        n_tests++; if (mmio_rdata !== m_rd) begin n_fail++; $display("FAIL rnd_level got %h want %h", mmio_rdata, m_rd); end
        mmio(1'b0, REG_BTN_PRESSED, 32'h0);
        n_tests++; if (mmio_rdata !== m_rd) begin n_fail++; $display("FAIL rnd_pressed got %h want %h", mmio_rdata, m_rd); end
    endtask

    task automatic test_async_reset();
        mmio(1'b1, REG_LED, 32'h0000_00FF);
        btn_raw = 4'b0100;
        repeat (20) tick();
        mmio(1'b0, REG_BTN_LEVEL, 32'h0);
        n_tests++; if (mmio_rdata !== 32'h4) begin n_fail++; $display("FAIL pre_rst_level got %h want 4", mmio_rdata); end
        n_tests++; if (LED !== 16'h00FF) begin n_fail++; $display("FAIL pre_rst_led got %h want 00ff", LED); end
        btn_raw = 4'b0000;
        repeat (4) tick();
        #2 CPU_RESETN = 1'b0;
        #1;
        n_tests++; if (LED !== '0) begin n_fail++; $display("FAIL arst_led got %h want 0", LED); end
        n_tests++; if (mmio_rdata !== 32'h0) begin n_fail++; $display("FAIL arst_rdata got %h want 0", mmio_rdata); end
        n_tests++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL arst_sys_rst_n got %b want 0", sys_rst_n); end
        n_tests++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL arst_cpu_ce got %b want 0", cpu_ce); end
        n_tests++; if (dut.r_pressed !== '0) begin n_fail++; $display("FAIL arst_pressed got %h want 0", dut.r_pressed); end
        n_tests++; if (dut.w_stable !== '0) begin n_fail++; $display("FAIL arst_stable got %h want 0", dut.w_stable); end
        model_reset();
        @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        repeat (2) tick();
        mmio(1'b0, REG_BTN_PRESSED, 32'h0);
        n_tests++; if (mmio_rdata !== 32'h0) begin n_fail++; $display("FAIL post_rst_pressed got %h want 0", mmio_rdata); end
    endtask

    initial begin
        test_reset();
        test_clock_enable();
        test_debounce_glitch();
        test_debounce_press();
        test_pressed_clear();
        test_led();
        test_cycles();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_board_io_ctrl
`default_nettype wire
